// File: rtl/riscv_pkg.sv
// Shared fetch-stage types for the 16-bit core.
// Purely declarative: no logic, no latency, no flow control.
package riscv_pkg;

  localparam int ILEN = 16;

  typedef logic [15:0] pc_t;

  typedef struct packed {
    pc_t             pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Flushable synchronous FIFO of fetch entries; a push is visible at the head one cycle later.
// Push when full and pop when empty are ignored; flush wins over both.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, credit-limited in-order requests, response queue to decode (1 cycle rsp->decode).
// Requests stall while outstanding + queued reaches QUEUE_DEPTH; decode backpressure holds the head.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [15:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [15:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [15:0] instr_o,
  output logic [15:0] pc_o
);

  localparam int  CW       = $clog2(QUEUE_DEPTH) + 1;
  localparam pc_t START_PC = RESET_PC & 16'hFFFE;

  pc_t          fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  fetch_state_t state_q, state_d;

  logic [CW-1:0] iq_count, tq_count;
  logic          iq_full, iq_empty, tq_full, tq_empty;
  fetch_entry_t  iq_head, tq_head, iq_push_data, tq_push_data;
  logic [CW:0]   in_use;
  logic          req_hs, rsp_hs, accept_rsp, pop_hs;

  // Credit depends on registered state only, so redirect never reaches the request valid.
  assign in_use           = {1'b0, outstanding_q} + {1'b0, iq_count};
  assign imem_req_valid_o = (in_use < (CW+1)'(QUEUE_DEPTH)) && !rst_i;
  assign imem_req_addr_o  = fetch_pc_q;

  assign req_hs     = imem_req_valid_o && imem_req_ready_i;
  assign rsp_hs     = imem_rsp_valid_i;
  assign accept_rsp = rsp_hs && !redirect_i && (state_q == RUN);
  assign pop_hs     = instr_valid_o && instr_ready_i && !redirect_i;

  assign tq_push_data = '{pc: fetch_pc_q, instr: '0};
  assign iq_push_data = '{pc: tq_head.pc, instr: imem_rsp_data_i};

  assign instr_valid_o = !iq_empty;
  assign instr_o       = instr_valid_o ? iq_head.instr : '0;
  assign pc_o          = instr_valid_o ? iq_head.pc : '0;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_tag_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (req_hs),
    .push_data_i (tq_push_data),
    .pop_i       (accept_rsp),
    .flush_i     (redirect_i),
    .head_o      (tq_head),
    .count_o     (tq_count),
    .full_o      (tq_full),
    .empty_o     (tq_empty)
  );

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_instr_queue (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (accept_rsp),
    .push_data_i (iq_push_data),
    .pop_i       (pop_hs),
    .flush_i     (redirect_i),
    .head_o      (iq_head),
    .count_o     (iq_count),
    .full_o      (iq_full),
    .empty_o     (iq_empty)
  );

  // outstanding_d already folds in this cycle's request and response, which is exactly the drop count.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(req_hs) - CW'(rsp_hs);
    drop_cnt_d    = drop_cnt_q;
    state_d       = state_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & 16'hFFFE;
      drop_cnt_d = outstanding_d;
      state_d    = (outstanding_d != '0) ? DRAIN : RUN;
    end else begin
      if (req_hs) begin
        fetch_pc_d = fetch_pc_q + 16'd2;
      end
      if ((state_q == DRAIN) && rsp_hs) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
        if (drop_cnt_q == CW'(1)) begin
          state_d = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q    <= START_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      state_q       <= RUN;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      state_q       <= state_d;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i) !(imem_rsp_valid_i && iq_full));
  assert property (@(posedge clk_i) disable iff (rst_i) !(req_hs && tq_full));
  assert property (@(posedge clk_i) disable iff (rst_i) !(accept_rsp && tq_empty));
  assert property (@(posedge clk_i) disable iff (rst_i) tq_count <= outstanding_q);
  assert property (@(posedge clk_i) disable iff (rst_i) tq_empty || (tq_head.instr == '0));

endmodule
